// File: rtl/dense_layer_pkg.sv
// Shared types, widths and the round/saturate helper for the dense layer engine.
package dense_layer_pkg;

  localparam int DATA_W       = 16;
  localparam int ACC_W        = 40;
  localparam int DL_IN_N      = 15;
  localparam int DL_OUT_N     = 15;
  localparam int DL_FRAC_BITS = 8;

  typedef enum logic [1:0] {IDLE, MAC, FINAL, OUT} state_e;

  typedef struct packed {
    logic signed [DATA_W-1:0] data;
    logic                     sat;
  } sat_res_t;

  // Width helper that never returns 0, so single-neuron layers still get a 1-bit bus.
  function automatic int width_of(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  // Round half up, drop frac_bits, clamp to the signed DATA_W range.
  function automatic sat_res_t sat_round(input logic signed [ACC_W-1:0] acc, input int frac_bits);
    logic signed [ACC_W-1:0] r;
    sat_res_t res;
    r = acc;
    if (frac_bits > 0) r = acc + $signed(ACC_W'(1) << (frac_bits - 1));
    r = r >>> frac_bits;
    if (r > SAT_MAX) begin
      res.data = SAT_MAX[DATA_W-1:0];
      res.sat  = 1'b1;
    end else if (r < SAT_MIN) begin
      res.data = SAT_MIN[DATA_W-1:0];
      res.sat  = 1'b1;
    end else begin
      res.data = r[DATA_W-1:0];
      res.sat  = 1'b0;
    end
    return res;
  endfunction

endpackage

// File: rtl/dense_layer_mac.sv
// Registered signed multiply-accumulate; product is sign-extended into the accumulator.
module dense_layer_mac
  import dense_layer_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr,
  input  logic                    en,
  input  logic [DATA_W-1:0]       a,
  input  logic [DATA_W-1:0]       b,
  output logic signed [ACC_W-1:0] acc
);

  logic signed [2*DATA_W-1:0] prod;

  assign prod = $signed(a) * $signed(b);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc + $signed({{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod});
    end
  end

endmodule

// File: rtl/dense_layer_engine.sv
// Time-multiplexed dense layer: one MAC per cycle, one output neuron per beat.
// Build option DENSE_LAYER_RELU_EN clamps negative results to zero after saturation.
// Handshakes: a transfer happens on the rising edge where valid and ready are both high;
// out_valid with its data/idx/last is held unchanged until that edge.
module dense_layer_engine
  import dense_layer_pkg::*;
#(
  parameter int IN_N      = DL_IN_N,
  parameter int OUT_N     = DL_OUT_N,
  parameter int FRAC_BITS = DL_FRAC_BITS
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               start_valid,
  output logic                               start_ready,
  input  logic [IN_N*DATA_W-1:0]             in_vec,
  input  logic [OUT_N*DATA_W-1:0]            bias_vec,
  output logic                               w_rd_en,
  output logic [width_of(IN_N*OUT_N)-1:0]    w_addr,
  input  logic [DATA_W-1:0]                  w_rdata,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [DATA_W-1:0]                  out_data,
  output logic [width_of(OUT_N)-1:0]         out_idx,
  output logic                               out_last,
  output logic                               busy,
  output logic                               sat_flag,
  output state_e                             dbg_state
);

  localparam int AW = width_of(IN_N*OUT_N);
  localparam int IW = width_of(OUT_N);
  localparam int JW = $clog2(IN_N + 1);

  state_e                  state, state_n;
  logic [IW-1:0]           o_cnt;
  logic [JW-1:0]           j_cnt, jq;
  logic                    rd_q;
  logic [DATA_W-1:0]       in_lat   [IN_N];
  logic [DATA_W-1:0]       bias_lat [OUT_N];
  logic                    mac_clr;
  logic                    last_o;
  logic signed [ACC_W-1:0] acc, bias_ext;
  logic [DATA_W-1:0]       bias_sel;
  sat_res_t                fin;
  logic [DATA_W-1:0]       fin_data;

  assign last_o    = (o_cnt == IW'(OUT_N - 1));
  assign out_idx   = o_cnt;
  assign busy      = (state != IDLE);
  assign dbg_state = state;

  always_comb begin
    state_n     = state;
    start_ready = 1'b0;
    w_rd_en     = 1'b0;
    w_addr      = '0;
    out_valid   = 1'b0;
    out_last    = 1'b0;
    mac_clr     = 1'b0;
    case (state)
      IDLE: begin
        start_ready = 1'b1;
        if (start_valid) state_n = MAC;
      end
      MAC: begin
        // j == IN_N is the drain cycle that absorbs the last read's data.
        if (j_cnt < JW'(IN_N)) begin
          w_rd_en = 1'b1;
          w_addr  = AW'(int'(o_cnt) * IN_N + int'(j_cnt));
        end else begin
          state_n = FINAL;
        end
      end
      FINAL: state_n = OUT;
      OUT: begin
        out_valid = 1'b1;
        out_last  = last_o;
        if (out_ready) begin
          mac_clr = 1'b1;
          state_n = last_o ? IDLE : MAC;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign bias_sel = bias_lat[o_cnt];
  assign bias_ext = $signed({{(ACC_W-DATA_W){bias_sel[DATA_W-1]}}, bias_sel}) <<< FRAC_BITS;
  assign fin      = sat_round(acc + bias_ext, FRAC_BITS);

`ifdef DENSE_LAYER_RELU_EN
  assign fin_data = fin.data[DATA_W-1] ? '0 : fin.data;
`else
  assign fin_data = fin.data;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      o_cnt    <= '0;
      j_cnt    <= '0;
      jq       <= '0;
      rd_q     <= 1'b0;
      out_data <= '0;
      sat_flag <= 1'b0;
      for (int k = 0; k < IN_N; k++) in_lat[k] <= '0;
      for (int k = 0; k < OUT_N; k++) bias_lat[k] <= '0;
    end else begin
      state <= state_n;
      rd_q  <= w_rd_en;
      if (w_rd_en) jq <= j_cnt;
      case (state)
        IDLE: begin
          if (start_valid) begin
            for (int k = 0; k < IN_N; k++) in_lat[k] <= in_vec[k*DATA_W +: DATA_W];
            for (int k = 0; k < OUT_N; k++) bias_lat[k] <= bias_vec[k*DATA_W +: DATA_W];
            sat_flag <= 1'b0;
            o_cnt    <= '0;
            j_cnt    <= '0;
          end
        end
        MAC: begin
          if (j_cnt < JW'(IN_N)) j_cnt <= j_cnt + 1'b1;
        end
        FINAL: begin
          out_data <= fin_data;
          if (fin.sat) sat_flag <= 1'b1;
        end
        OUT: begin
          if (out_ready) begin
            j_cnt <= '0;
            if (!last_o) o_cnt <= o_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  dense_layer_mac u_mac (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (mac_clr),
    .en    (rd_q),
    .a     (w_rdata),
    .b     (in_lat[jq]),
    .acc   (acc)
  );

endmodule

// File: tb/tb_dense_layer_engine.sv
// Self-checking bench for dense_layer_engine: directed Q8.8 patterns plus randomized layers
// compared against an arithmetic reference model, with backpressure and mid-run reset.
module tb_dense_layer_engine;
  import dense_layer_pkg::*;

  localparam int IN_N = 15;
  localparam int OUT_N = 15;
  localparam int FRAC = 8;
  localparam int W = 16;
  localparam int LAT = IN_N + 3;

  logic                   clk, rst_n;
  logic                   start_valid, start_ready;
  logic [IN_N*W-1:0]      in_vec;
  logic [OUT_N*W-1:0]     bias_vec;
  logic                   w_rd_en;
  logic [7:0]             w_addr;
  logic [W-1:0]           w_rdata;
  logic                   out_valid, out_ready, out_last, busy, sat_flag;
  logic [W-1:0]           out_data;
  logic [3:0]             out_idx;
  state_e                 dbg_state;

  logic [W-1:0] in_a [IN_N];
  logic [W-1:0] bias_a [OUT_N];
  logic [W-1:0] wmem [IN_N*OUT_N];

  int vectors = 0;
  int miscompares = 0;

  logic [W-1:0] exp_q[$];
  bit           exp_sat;
  logic [W-1:0] got_data[$];
  int           got_idx[$];
  bit           got_last[$];
  int           got_cyc[$];
  int           first_cyc, unstable, ready_while_busy;
  bit           timed_out, rd_in_stall;

  dense_layer_engine dut (
    .clk(clk), .rst_n(rst_n), .start_valid(start_valid), .start_ready(start_ready),
    .in_vec(in_vec), .bias_vec(bias_vec), .w_rd_en(w_rd_en), .w_addr(w_addr),
    .w_rdata(w_rdata), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_idx(out_idx), .out_last(out_last), .busy(busy), .sat_flag(sat_flag),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Weight RAM with one-cycle read latency.
  always @(posedge clk) if (w_rd_en) w_rdata <= wmem[w_addr];

  // ---------------- reference model ----------------
  function automatic void model_neuron(input int o, output logic [W-1:0] d, output bit sat);
    longint acc;
    acc = 0;
    for (int j = 0; j < IN_N; j++)
      acc += longint'($signed(wmem[o*IN_N+j])) * longint'($signed(in_a[j]));
    acc += longint'($signed(bias_a[o])) * (longint'(1) << FRAC);
    acc += longint'(1) << (FRAC - 1);
    acc = acc >>> FRAC;
    sat = 1'b0;
    if (acc > 32767) begin acc = 32767; sat = 1'b1; end
    else if (acc < -32768) begin acc = -32768; sat = 1'b1; end
`ifdef DENSE_LAYER_RELU_EN
    if (acc < 0) acc = 0;
`endif
    d = acc[W-1:0];
  endfunction

  function automatic void build_expected();
    logic [W-1:0] d;
    bit s;
    exp_q.delete();
    exp_sat = 1'b0;
    for (int o = 0; o < OUT_N; o++) begin
      model_neuron(o, d, s);
      exp_q.push_back(d);
      exp_sat |= s;
    end
  endfunction

  // ---------------- driver tasks ----------------
  task automatic load_pattern(input int kind);
    for (int j = 0; j < IN_N; j++) begin
      case (kind)
        0, 3:    in_a[j] = 16'((j + 1) << 8);
        1:       in_a[j] = 16'h7FFF;
        2:       in_a[j] = 16'h8000;
        6:       in_a[j] = 16'($urandom_range(0, 1023)) - 16'd512;
        7:       in_a[j] = 16'($urandom);
        default: in_a[j] = 16'h0000;
      endcase
    end
    if (kind == 4) in_a[0] = 16'h0180;
    if (kind == 5) in_a[0] = 16'h0001;
    for (int i = 0; i < IN_N*OUT_N; i++) begin
      case (kind)
        0:       wmem[i] = 16'h0100;
        1, 2:    wmem[i] = 16'h7FFF;
        3:       wmem[i] = 16'hFF00;
        6:       wmem[i] = 16'($urandom_range(0, 1023)) - 16'd512;
        7:       wmem[i] = 16'($urandom);
        default: wmem[i] = 16'h0000;
      endcase
    end
    if (kind == 4 || kind == 5) wmem[0] = 16'h0080;
    for (int o = 0; o < OUT_N; o++) begin
      case (kind)
        0, 3:    bias_a[o] = 16'h0500;
        1, 2:    bias_a[o] = 16'h7FFF;
        6:       bias_a[o] = 16'($urandom_range(0, 4095)) - 16'd2048;
        7:       bias_a[o] = 16'($urandom);
        default: bias_a[o] = 16'h0000;
      endcase
    end
    for (int j = 0; j < IN_N; j++) in_vec[j*W +: W] = in_a[j];
    for (int o = 0; o < OUT_N; o++) bias_vec[o*W +: W] = bias_a[o];
    build_expected();
  endtask

  // Runs one layer and records every accepted beat; stalls out_ready on one beat if asked.
  task automatic run_layer(input int stall_beat, input int stall_len, input bit poke_start);
    int cyc, n;
    bit done, stalled;
    logic [W-1:0] hd;
    logic [3:0] hi;
    logic hl;
    got_data.delete(); got_idx.delete(); got_last.delete(); got_cyc.delete();
    timed_out = 1'b0; unstable = 0; ready_while_busy = 0; rd_in_stall = 1'b0;
    first_cyc = -1; done = 1'b0; stalled = 1'b0;
    out_ready = 1'b1;
    start_valid = 1'b1;
    n = 0;
    while (!start_ready && n < 100) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    start_valid = 1'b0;
    cyc = 1;
    while (!done && cyc < 3000) begin
      if (out_valid) begin
        if (first_cyc < 0) first_cyc = cyc;
        if (got_data.size() == stall_beat && stall_len > 0 && !stalled) begin
          stalled = 1'b1;
          out_ready = 1'b0;
          hd = out_data; hi = out_idx; hl = out_last;
          for (int k = 0; k < stall_len; k++) begin
            if (poke_start && k == 1) begin
              start_valid = 1'b1;
              if (start_ready) ready_while_busy++;
            end
            @(posedge clk); #1; cyc++;
            start_valid = 1'b0;
            if (!out_valid || out_data !== hd || out_idx !== hi || out_last !== hl) unstable++;
            if (w_rd_en) rd_in_stall = 1'b1;
          end
          out_ready = 1'b1;
        end
        got_data.push_back(out_data);
        got_idx.push_back(int'(out_idx));
        got_last.push_back(out_last);
        got_cyc.push_back(cyc);
        if (out_last) done = 1'b1;
      end
      @(posedge clk); #1; cyc++;
    end
    if (!done) timed_out = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0; start_valid = 1'b0; out_ready = 1'b0;
    in_vec = '0; bias_vec = '0;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({start_ready, busy, out_valid, w_rd_en, out_last, sat_flag} !== 6'b100000) begin
      miscompares++;
      $display("FAIL reset_flags: got %b expected 100000",
               {start_ready, busy, out_valid, w_rd_en, out_last, sat_flag});
    end
    vectors++;
    if ({w_addr, out_data, out_idx} !== '0) begin
      miscompares++;
      $display("FAIL reset_buses: got addr=%h data=%h idx=%h expected all zero", w_addr, out_data, out_idx);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_baseline();
    int bad_gap;
    load_pattern(0);
    run_layer(-1, 0, 1'b0);
    vectors++;
    if (timed_out || got_data.size() != OUT_N) begin
      miscompares++;
      $display("FAIL baseline_beats: got %0d beats (timeout=%0d) expected %0d", got_data.size(), timed_out, OUT_N);
    end
    for (int i = 0; i < got_data.size() && i < OUT_N; i++) begin
      vectors++;
      if (got_data[i] !== exp_q[i] || got_data[i] !== 16'h7D00 || got_idx[i] !== i || got_last[i] !== (i == OUT_N-1)) begin
        miscompares++;
        $display("FAIL baseline_beat%0d: got data=%h idx=%0d last=%0d expected data=%h idx=%0d last=%0d",
                 i, got_data[i], got_idx[i], got_last[i], exp_q[i], i, (i == OUT_N-1));
      end
    end
    vectors++;
    if (first_cyc !== LAT) begin
      miscompares++;
      $display("FAIL baseline_latency: got cycle %0d expected %0d", first_cyc, LAT);
    end
    bad_gap = 0;
    for (int i = 1; i < got_cyc.size(); i++) if (got_cyc[i] - got_cyc[i-1] != LAT) bad_gap++;
    vectors++;
    if (bad_gap != 0) begin
      miscompares++;
      $display("FAIL baseline_throughput: got %0d beats off the %0d-cycle spacing expected 0", bad_gap, LAT);
    end
    vectors++;
    if (sat_flag !== 1'b0) begin
      miscompares++;
      $display("FAIL baseline_sat: got %b expected 0", sat_flag);
    end
  endtask

  task automatic test_rounding();
    logic [W-1:0] want;
    for (int kind = 4; kind <= 5; kind++) begin
      load_pattern(kind);
      want = (kind == 4) ? 16'h00C0 : 16'h0001;
      run_layer(-1, 0, 1'b0);
      vectors++;
      if (timed_out || got_data.size() != OUT_N || got_data[0] !== want) begin
        miscompares++;
        $display("FAIL rounding_k%0d: got %0d beats first=%h expected %0d beats first=%h",
                 kind, got_data.size(), (got_data.size() > 0) ? got_data[0] : 16'hxxxx, OUT_N, want);
      end
      for (int i = 0; i < got_data.size() && i < OUT_N; i++) begin
        vectors++;
        if (got_data[i] !== exp_q[i]) begin
          miscompares++;
          $display("FAIL rounding_k%0d_beat%0d: got %h expected %h", kind, i, got_data[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_negative();
    logic [W-1:0] want;
`ifdef DENSE_LAYER_RELU_EN
    want = 16'h0000;
`else
    want = 16'h8D00;
`endif
    load_pattern(3);
    run_layer(-1, 0, 1'b0);
    vectors++;
    if (timed_out || got_data.size() != OUT_N) begin
      miscompares++;
      $display("FAIL negative_beats: got %0d beats expected %0d", got_data.size(), OUT_N);
    end
    for (int i = 0; i < got_data.size() && i < OUT_N; i++) begin
      vectors++;
      if (got_data[i] !== exp_q[i] || got_data[i] !== want) begin
        miscompares++;
        $display("FAIL negative_beat%0d: got %h expected %h", i, got_data[i], want);
      end
    end
    vectors++;
    if (sat_flag !== 1'b0) begin
      miscompares++;
      $display("FAIL negative_sat: got %b expected 0", sat_flag);
    end
  endtask

  task automatic test_saturation();
    logic [W-1:0] want;
    for (int kind = 1; kind <= 2; kind++) begin
      load_pattern(kind);
      want = (kind == 1) ? 16'h7FFF : 16'h8000;
`ifdef DENSE_LAYER_RELU_EN
      if (kind == 2) want = 16'h0000;
`endif
      run_layer(-1, 0, 1'b0);
      vectors++;
      if (timed_out || got_data.size() != OUT_N) begin
        miscompares++;
        $display("FAIL saturation_k%0d_beats: got %0d expected %0d", kind, got_data.size(), OUT_N);
      end
      for (int i = 0; i < got_data.size() && i < OUT_N; i++) begin
        vectors++;
        if (got_data[i] !== exp_q[i] || got_data[i] !== want) begin
          miscompares++;
          $display("FAIL saturation_k%0d_beat%0d: got %h expected %h", kind, i, got_data[i], want);
        end
      end
      vectors++;
      if (sat_flag !== 1'b1 || exp_sat !== 1'b1) begin
        miscompares++;
        $display("FAIL saturation_k%0d_flag: got %b expected 1", kind, sat_flag);
      end
    end
  endtask

  task automatic test_backpressure();
    int bad;
    load_pattern(0);
    run_layer(3, 5, 1'b1);
    vectors++;
    if (timed_out || got_data.size() != OUT_N) begin
      miscompares++;
      $display("FAIL backpressure_beats: got %0d expected %0d", got_data.size(), OUT_N);
    end
    for (int i = 0; i < got_data.size() && i < OUT_N; i++) begin
      vectors++;
      if (got_data[i] !== exp_q[i] || got_idx[i] !== i || got_last[i] !== (i == OUT_N-1)) begin
        miscompares++;
        $display("FAIL backpressure_beat%0d: got data=%h idx=%0d expected data=%h idx=%0d",
                 i, got_data[i], got_idx[i], exp_q[i], i);
      end
    end
    vectors++;
    if (unstable != 0 || rd_in_stall) begin
      miscompares++;
      $display("FAIL backpressure_hold: got %0d unstable samples, rd_en_seen=%0d expected 0 and 0",
               unstable, rd_in_stall);
    end
    vectors++;
    if (ready_while_busy != 0) begin
      miscompares++;
      $display("FAIL backpressure_start_ready: got %0d cycles ready while busy expected 0", ready_while_busy);
    end
    bad = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid || busy) bad++;
    end
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL backpressure_ignored_start: got %0d busy/valid cycles after run expected 0", bad);
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 5; r++) begin
      load_pattern((r == 4) ? 7 : 6);
      run_layer($urandom_range(0, OUT_N-1), $urandom_range(0, 4), 1'b0);
      vectors++;
      if (timed_out || got_data.size() != OUT_N) begin
        miscompares++;
        $display("FAIL random%0d_beats: got %0d expected %0d", r, got_data.size(), OUT_N);
      end
      for (int i = 0; i < got_data.size() && i < OUT_N; i++) begin
        vectors++;
        if (got_data[i] !== exp_q[i] || got_idx[i] !== i || got_last[i] !== (i == OUT_N-1)) begin
          miscompares++;
          $display("FAIL random%0d_beat%0d: got data=%h idx=%0d expected data=%h idx=%0d",
                   r, i, got_data[i], got_idx[i], exp_q[i], i);
        end
      end
      vectors++;
      if (sat_flag !== exp_sat) begin
        miscompares++;
        $display("FAIL random%0d_sat: got %b expected %b", r, sat_flag, exp_sat);
      end
    end
  endtask

  task automatic test_reset_midrun();
    int n, bad;
    bit found;
    load_pattern(1);
    out_ready = 1'b1;
    start_valid = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0;
    found = 1'b0; n = 0;
    while (!found && n < 1000) begin
      if (out_idx == 4'd7 && w_rd_en) found = 1'b1;
      else begin @(posedge clk); #1; n++; end
    end
    vectors++;
    if (!found) begin
      miscompares++;
      $display("FAIL midrun_reach_neuron7: got no MAC on neuron 7 within %0d cycles expected one", n);
    end
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (sat_flag !== exp_sat) begin
      miscompares++;
      $display("FAIL midrun_sat_before_reset: got %b expected %b", sat_flag, exp_sat);
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({start_ready, busy, out_valid, w_rd_en, out_last, sat_flag} !== 6'b100000 ||
        {w_addr, out_data, out_idx} !== '0) begin
      miscompares++;
      $display("FAIL midrun_reset_values: got flags=%b addr=%h data=%h idx=%h expected 100000 and zeros",
               {start_ready, busy, out_valid, w_rd_en, out_last, sat_flag}, w_addr, out_data, out_idx);
    end
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    bad = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (out_valid || busy) bad++;
    end
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL midrun_no_partial_beat: got %0d busy/valid cycles expected 0", bad);
    end
    load_pattern(0);
    run_layer(-1, 0, 1'b0);
    vectors++;
    if (timed_out || got_data.size() != OUT_N) begin
      miscompares++;
      $display("FAIL midrun_restart_beats: got %0d expected %0d", got_data.size(), OUT_N);
    end
    for (int i = 0; i < got_data.size() && i < OUT_N; i++) begin
      vectors++;
      if (got_data[i] !== exp_q[i] || got_idx[i] !== i || got_last[i] !== (i == OUT_N-1)) begin
        miscompares++;
        $display("FAIL midrun_restart_beat%0d: got data=%h idx=%0d expected data=%h idx=%0d",
                 i, got_data[i], got_idx[i], exp_q[i], i);
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    w_rdata = '0;
    test_reset();
    test_baseline();
    test_rounding();
    test_negative();
    test_saturation();
    test_backpressure();
    test_random();
    test_reset_midrun();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dense_layer_engine.md
Name: dense_layer_engine

Overview:
- Sequential, time-multiplexed successor to the combinational dense-layer accelerator; computes out[o] = sat(round(sum_j W[o][j]*in[j] + b[o])) in signed fixed point.
- One MAC per cycle. Weights are fetched from external weight RAM (1-cycle read latency); results stream out one neuron per valid/ready beat.
- Sits between the layer sequencer (start handshake) and the next layer's input buffer.

Parameters:
- IN_N, 15, input neurons per layer.
- OUT_N, 15, output neurons per layer.
- DATA_W, 16, width of inputs, weights, biases and outputs (signed two's complement).
- FRAC_BITS, 8, fractional bits of all operands (Q(DATA_W-FRAC_BITS).FRAC_BITS); range 0..DATA_W-1.
- ACC_W, 40, accumulator width; must be >= 2*DATA_W + clog2(IN_N) + 1.

Ports:
- clk  in  1  single clock; all flops rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- start_valid  in  1  request to run one layer.
- start_ready  out  1  high only in IDLE.
- in_vec  in  IN_N*DATA_W  input vector, element j at bits [j*DATA_W +: DATA_W]; sampled on start handshake.
- bias_vec  in  OUT_N*DATA_W  biases, same packing; sampled on start handshake.
- w_rd_en  out  1  weight read strobe.
- w_addr  out  clog2(IN_N*OUT_N)  weight address = o*IN_N + j (row-major).
- w_rdata  in  DATA_W  weight data, valid one cycle after w_rd_en.
- out_valid  out  1  result beat valid.
- out_ready  in  1  downstream accept.
- out_data  out  DATA_W  result for neuron out_idx.
- out_idx  out  clog2(OUT_N)  neuron index of current beat.
- out_last  out  1  high with the beat for o = OUT_N-1.
- busy  out  1  high in any state except IDLE.
- sat_flag  out  1  sticky per run: set if any output saturated; cleared on start handshake.

Behaviour:
- Reset: state IDLE; all outputs 0 except start_ready=1; latched vectors, counters and accumulator cleared.
- FSM states: IDLE -> MAC -> FINAL -> OUT -> (MAC for next o | IDLE).
- IDLE: on start_valid & start_ready, latch in_vec and bias_vec, clear sat_flag, set o=0, j=0, go to MAC. start_valid while busy is ignored (not queued).
- MAC: issue w_rd_en with w_addr = o*IN_N+j for j = 0..IN_N-1, one per cycle; the product of w_rdata and in[j-1] is accumulated the following cycle (sign-extended to ACC_W). After the last read, one drain cycle, then FINAL. MAC phase takes IN_N+1 cycles; w_rd_en is low outside MAC.
- FINAL (1 cycle): acc + (bias sign-extended << FRAC_BITS); add 1<<(FRAC_BITS-1) if FRAC_BITS>0; arithmetic shift right by FRAC_BITS (round half up); saturate to [-2^(DATA_W-1), 2^(DATA_W-1)-1]; register into out_data, set out_valid, update sat_flag.
- OUT: out_valid, out_data, out_idx and out_last are held stable until out_ready. On the handshake, clear accumulator; if o==OUT_N-1 go to IDLE, else o++ and j=0, then MAC.
- Latency: first out_valid arrives IN_N+3 cycles after the start handshake. Per-neuron throughput is IN_N+3 cycles with out_ready tied high.
- Boundary conditions:
  - IN_N=1 and OUT_N=1 must work.
  - The accumulator never wraps, given the ACC_W constraint.
  - out_ready high while out_valid is low has no effect.
  - Reset asserted mid-run aborts immediately to reset values; no partial beat is emitted after rst_n deasserts.

Optional Feature:
- Macro DENSE_LAYER_RELU_EN.
- Defined: ReLU is applied after saturation in FINAL (negative results become 0). sat_flag still reflects saturation before ReLU.
- Undefined: signed saturated result is output unchanged.

Decomposition:
- Package dense_layer_pkg holds:
  - state enum typedef (IDLE, MAC, FINAL, OUT);
  - function sat_round(acc, frac_bits) returning DATA_W-wide result plus saturation bit;
  - localparam helpers for address and index widths.
- One sub-module, dense_layer_mac: registered signed multiply-accumulate with clear/enable. FSM, addressing and output handshake stay in the top.

Test Plan:
- Q8.8 baseline: in[j]=(j+1)<<8, all weights 0x0100, all biases 0x0500, out_ready=1 -> 15 beats, each out_data=0x7D00 (125.0), out_idx 0..14, out_last only on idx 14, sat_flag=0, first valid 18 cycles after start.
- Saturation: all inputs and weights 0x7FFF, bias 0x7FFF -> every out_data=0x7FFF and sat_flag=1. All inputs 0x8000 with weights 0x7FFF -> 0x8000.
- Negative/ReLU: in[j]=(j+1)<<8, weights 0xFF00, biases 0x0500 -> out_data=0x8D00 (-115.0) without macro; 0x0000 with DENSE_LAYER_RELU_EN, sat_flag=0.
- Backpressure: hold out_ready low 5 cycles on beat 3 -> out_data/out_idx stable, w_rd_en stays low, no beat lost or duplicated. A start_valid pulse during the run is ignored (start_ready=0).
- Reset mid-run: assert rst_n low during MAC of neuron 7 -> all outputs return to reset values at once. A new start after release yields the full correct 15-beat sequence.
- Rounding, FRAC_BITS=8: one input 0x0180 (1.5), weight 0x0080 (0.5), bias 0 -> out_data=0x00C0. Product 0x0001 x 0x0080 -> rounds to 0x0001 (half up).
